// File: rtl/ctrl_decode_fsm.sv
// MyRISC instruction decoder: valid/ready word intake, escape+immediate pairing,
// registered decoded record with control strobes, STOP/resume halt and retire counter.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_RUN   | decode single words; escape words arm an immediate fetch
// ST_IMM   | escape seen, next accepted word is the immediate
// ST_HALT  | STOP decoded, intake stalled until resume pulse
module ctrl_decode_fsm #(
    parameter int IW   = 9,
    parameter int OPW  = 4,
    parameter int FW   = IW - OPW,
    parameter int SUBW = 4,
    parameter int NSUB = 7,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   instr,
    input  logic            resume,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_op,
    output logic [SUBW-1:0] out_sub,
    output logic            out_is_imm,
    output logic [FW-1:0]   out_field,
    output logic [IW-1:0]   out_imm,
    output logic            ctl_reg_we,
    output logic            ctl_mem_re,
    output logic            ctl_mem_we,
    output logic            ctl_branch,
    output logic            out_illegal,
    output logic            halted,
    output logic [CW-1:0]   retired
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_IMM  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [OPW-1:0] OP_ESC  = OPW'(14);
    localparam logic [OPW-1:0] OP_STOP = OPW'(15);
    localparam logic [SUBW:0]  NSUB_W  = (SUBW + 1)'(NSUB);

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [SUBW-1:0] sub;
        logic            is_imm;
        logic [FW-1:0]   field;
        logic [IW-1:0]   imm;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic            branch;
        logic            illegal;
    } rec_t;

    logic [1:0]      state_q, state_d;
    logic [SUBW-1:0] pend_sub_q, pend_sub_d;
    logic            out_valid_q, out_valid_d;
    rec_t            rec_q, rec_d;
    logic [CW-1:0]   retired_q, retired_d;

    logic            accept;
    logic            handoff;
    logic [OPW-1:0]  opcode;
    logic [SUBW-1:0] esc_sub;
    logic            sub_ok;
    logic            dec_reg_we, dec_mem_re, dec_mem_we, dec_branch;

    assign opcode   = instr[IW-1:IW-OPW];
    assign esc_sub  = instr[SUBW-1:0];
    assign sub_ok   = ({1'b0, esc_sub} < NSUB_W);
    assign in_ready = (state_q != ST_HALT) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;

    always_comb begin
        dec_reg_we = 1'b0;
        dec_mem_re = 1'b0;
        dec_mem_we = 1'b0;
        dec_branch = 1'b0;
        case (opcode)
            OPW'(0), OPW'(1), OPW'(2), OPW'(3),
            OPW'(9), OPW'(10), OPW'(11), OPW'(12), OPW'(13): dec_reg_we = 1'b1;
            OPW'(7): begin
                dec_reg_we = 1'b1;
                dec_mem_re = 1'b1;
            end
            OPW'(8): dec_mem_we = 1'b1;
            OPW'(4), OPW'(5), OPW'(6): dec_branch = 1'b1;
            default: ;
        endcase
    end

    // A handoff empties the output register; an accept in the same cycle refills it.
    always_comb begin
        state_d     = state_q;
        pend_sub_d  = pend_sub_q;
        out_valid_d = out_valid_q && !out_ready;
        rec_d       = rec_q;
        retired_d   = retired_q + CW'(handoff);

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (opcode == OP_ESC) begin
                        if (sub_ok) begin
                            pend_sub_d = esc_sub;
                            state_d    = ST_IMM;
                        end else begin
                            out_valid_d   = 1'b1;
                            rec_d         = '0;
                            rec_d.op      = OP_ESC;
                            rec_d.sub     = esc_sub;
                            rec_d.is_imm  = 1'b1;
                            rec_d.illegal = 1'b1;
                        end
                    end else if (opcode == OP_STOP) begin
                        out_valid_d = 1'b1;
                        rec_d       = '0;
                        rec_d.op    = OP_STOP;
                        rec_d.field = instr[FW-1:0];
                        state_d     = ST_HALT;
                    end else begin
                        out_valid_d  = 1'b1;
                        rec_d        = '0;
                        rec_d.op     = opcode;
                        rec_d.field  = instr[FW-1:0];
                        rec_d.reg_we = dec_reg_we;
                        rec_d.mem_re = dec_mem_re;
                        rec_d.mem_we = dec_mem_we;
                        rec_d.branch = dec_branch;
                    end
                end
            end
            ST_IMM: begin
                if (accept) begin
                    out_valid_d  = 1'b1;
                    rec_d        = '0;
                    rec_d.op     = OP_ESC;
                    rec_d.sub    = pend_sub_q;
                    rec_d.is_imm = 1'b1;
                    rec_d.imm    = instr;
                    rec_d.reg_we = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            pend_sub_q  <= '0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_sub_q  <= pend_sub_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
            retired_q   <= retired_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = rec_q.op;
    assign out_sub     = rec_q.sub;
    assign out_is_imm  = rec_q.is_imm;
    assign out_field   = rec_q.field;
    assign out_imm     = rec_q.imm;
    assign ctl_reg_we  = rec_q.reg_we && out_valid_q;
    assign ctl_mem_re  = rec_q.mem_re && out_valid_q;
    assign ctl_mem_we  = rec_q.mem_we && out_valid_q;
    assign ctl_branch  = rec_q.branch && out_valid_q;
    assign out_illegal = rec_q.illegal && out_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign retired     = retired_q;

endmodule

// File: tb/tb_ctrl_decode_fsm.sv
// Scoreboard bench for ctrl_decode_fsm: a word-level reference model queues expected
// records on accept, a negedge monitor compares whatever the decoder presents.
`timescale 1ns/1ps
module tb_ctrl_decode_fsm;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [8:0]    instr = '0;
    logic          resume = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_op;
    logic [3:0]    out_sub;
    logic          out_is_imm;
    logic [4:0]    out_field;
    logic [8:0]    out_imm;
    logic          ctl_reg_we, ctl_mem_re, ctl_mem_we, ctl_branch;
    logic          out_illegal;
    logic          halted;
    logic [CW-1:0] retired;

    ctrl_decode_fsm #(.IW(9), .OPW(4), .FW(5), .SUBW(4), .NSUB(7), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_sub(out_sub), .out_is_imm(out_is_imm), .out_field(out_field),
        .out_imm(out_imm), .ctl_reg_we(ctl_reg_we), .ctl_mem_re(ctl_mem_re),
        .ctl_mem_we(ctl_mem_we), .ctl_branch(ctl_branch), .out_illegal(out_illegal),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] sub;
        logic       is_imm;
        logic [4:0] field;
        logic [8:0] imm;
        logic       rwe, mre, mwe, br, ill;
    } rec_t;

    rec_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         m_pending = 0;
    logic [3:0] m_sub = '0;
    bit         m_halted = 0;
    int         m_ret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per accepted word.
    task automatic model_accept(input logic [8:0] w);
        rec_t       e;
        logic [3:0] op;
        e  = '0;
        op = w[8:5];
        if (m_pending) begin
            e.op = 4'd14; e.sub = m_sub; e.is_imm = 1'b1; e.imm = w; e.rwe = 1'b1;
            exp_q.push_back(e);
            m_pending = 0;
        end else if (op == 4'd14) begin
            if (w[3:0] < 4'd7) begin
                m_pending = 1;
                m_sub     = w[3:0];
            end else begin
                e.op = 4'd14; e.sub = w[3:0]; e.is_imm = 1'b1; e.ill = 1'b1;
                exp_q.push_back(e);
            end
        end else if (op == 4'd15) begin
            e.op = 4'd15; e.field = w[4:0];
            exp_q.push_back(e);
            m_halted = 1;
        end else begin
            e.op    = op;
            e.field = w[4:0];
            e.rwe   = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
            e.mre   = (op == 4'd7);
            e.mwe   = (op == 4'd8);
            e.br    = op inside {4'd4, 4'd5, 4'd6};
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit v, input logic [8:0] w, input bit rdy, input bit res);
        bit acc, r;
        @(negedge clk);
        in_valid  = v;
        instr     = w;
        out_ready = rdy;
        resume    = res;
        #1;
        acc = in_valid && in_ready;
        r   = res && m_halted;
        @(posedge clk);
        if (acc) model_accept(w);
        if (r) m_halted = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        resume   = 1'b0;
        #1;
        exp_q.delete();
        m_pending = 0;
        m_halted  = 0;
        m_ret     = 0;
        chk("reset_outputs",
            {out_valid, out_op, out_sub, out_is_imm, out_field, out_imm, ctl_reg_we,
             ctl_mem_re, ctl_mem_we, ctl_branch, out_illegal, halted, retired}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        rec_t act;
        logic [CW-1:0] exp_ret;
        #2;
        if (reset_n) begin
            exp_ret = m_ret[CW-1:0];
            chk("halted", halted, m_halted);
            chk("in_ready", in_ready, !m_halted && (!out_valid || out_ready));
            chk("retired", retired, exp_ret);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record actual=valid expected=idle at %0t", $time);
                end else begin
                    act = {out_op, out_sub, out_is_imm, out_field, out_imm, ctl_reg_we,
                           ctl_mem_re, ctl_mem_we, ctl_branch, out_illegal};
                    chk("record", act, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        m_ret++;
                    end
                end
            end else begin
                chk("idle_strobes", {ctl_reg_we, ctl_mem_re, ctl_mem_we, ctl_branch, out_illegal}, 5'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] w;
        int sel;
        do_reset();

        step(1, 9'b0010_00101, 1, 0);
        step(1, 9'b0111_00011, 1, 0);
        step(1, 9'b1000_00001, 1, 0);
        step(0, 9'd0, 1, 0);
        step(0, 9'd0, 1, 0);
        #1 chk("retired_three", retired, 4'd3);

        step(1, 9'b1110_00100, 1, 0);
        step(1, 9'h0A5, 1, 0);
        step(0, 9'd0, 1, 0);
        step(0, 9'd0, 1, 0);
        #1 chk("retired_imm", retired, 4'd4);

        step(1, 9'b1110_01001, 1, 0);
        step(1, 9'b0001_00111, 1, 0);
        step(0, 9'd0, 1, 0);

        step(1, 9'b1111_00000, 0, 0);
        step(1, 9'b0010_00001, 0, 0);
        step(1, 9'b0010_00001, 0, 0);
        step(0, 9'd0, 0, 0);
        step(0, 9'd0, 1, 1);
        step(0, 9'd0, 1, 0);
        #1 chk("resumed", {halted, in_ready}, 2'b01);

        step(1, 9'b1110_00100, 1, 0);
        do_reset();
        step(1, 9'b0100_00010, 1, 0);
        step(0, 9'd0, 1, 0);
        step(0, 9'd0, 1, 0);
        #1 chk("retired_after_reset", retired, 4'd1);

        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 19);
            w   = 9'($urandom);
            if (sel < 5) w[8:5] = 4'hE;
            else if (sel == 5) w[8:5] = 4'hF;
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 9) < 8, w, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0);
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(0, 9'd0, 1, 1);
        step(0, 9'd0, 1, 0);
        chk("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_decode_fsm.md
# ctrl_decode_fsm

Parametrised, registered instruction decoder for the MyRISC core, sitting between instruction fetch and the register-file/ALU/memory stages. It accepts fetched words over a valid/ready handshake, splits out the major opcode, and expands two-word immediate sequences (escape word plus immediate word) into one decoded output. It emits per-instruction control strobes, enters a halt state on STOP until resumed, and keeps a retired-instruction counter.

## Interface
Parameters:
- IW, 9: instruction word width.
- OPW, 4: major opcode width; opcode is instr[IW-1:IW-OPW].
- FW, IW-OPW: operand field width, instr[FW-1:0].
- SUBW, 4: immediate sub-opcode width, taken from instr[SUBW-1:0] of the escape word; SUBW <= FW.
- NSUB, 7: number of legal sub-opcodes, 0..NSUB-1 (LI, GBI, SB0, SB1, ADDI, SUBI, LUTI).
- CW, 16: retired-instruction counter width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  decoder accepts instr this cycle.
- instr  in  IW  fetched instruction word.
- resume  in  1  single-cycle pulse; leaves HALT.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  downstream accepts record.
- out_op  out  OPW  major opcode (4'b1110 for immediate records).
- out_sub  out  SUBW  sub-opcode; 0 when out_is_imm=0.
- out_is_imm  out  1  record came from a two-word immediate sequence.
- out_field  out  FW  operand field of the single word; 0 for immediate records.
- out_imm  out  IW  immediate word; 0 for non-immediate records.
- ctl_reg_we, ctl_mem_re, ctl_mem_we, ctl_branch  out  1 each  control strobes, qualified by out_valid.
- out_illegal  out  1  undefined sub-opcode.
- halted  out  1  state is HALT.
- retired  out  CW  count of records handed off (out_valid && out_ready).

## Operation
- States: RUN, IMM_WAIT, HALT. Reset state RUN.
- Accept = in_valid && in_ready; in_ready = (state != HALT) && (!out_valid || out_ready).
- RUN, accepted opcode 4'b1110 (escape): sub = instr[SUBW-1:0]. sub < NSUB -> latch sub, go IMM_WAIT, no record. sub >= NSUB -> emit record out_op=1110, out_is_imm=1, out_sub=sub, out_illegal=1, all ctl_* = 0; stay RUN.
- IMM_WAIT, accepted word (any opcode, including 1111/1110): emit immediate record: out_is_imm=1, out_sub=latched sub, out_imm=word, ctl_reg_we=1; go RUN.
- RUN, accepted opcode 4'b1111 (STOP): emit record with out_op=1111, all ctl_* = 0; go HALT.
- RUN, other opcodes: emit record, out_field=instr[FW-1:0]. ctl_reg_we for 0000,0001,0010,0011,0111,1001,1010,1011,1100,1101; ctl_mem_re for 0111; ctl_mem_we for 1000; ctl_branch for 0100,0101,0110.
- HALT: in_ready=0; resume -> RUN next cycle; resume outside HALT ignored. An un-drained STOP record stays presented in HALT.
- retired increments by 1 on each output handshake, wraps 2^CW-1 -> 0; escape words are not counted.

## Timing
- Reset (async assert): out_valid=0, all record fields/strobes 0, out_illegal=0, halted=0, retired=0, state RUN, latched sub cleared; in_ready=1 one cycle after deassert-sync.
- Latency: accept of final word at edge N -> out_valid high after edge N; record held stable while out_valid && !out_ready.
- Throughput: one record per cycle for single-word instructions with out_ready=1; immediate records take two accepts.
- Handoff and new accept may occur in the same cycle (output register reloaded).
- halted asserts the cycle after STOP accept; deasserts the cycle after resume.
- Reset mid IMM_WAIT discards the pending sub-opcode; next word is decoded in RUN.

## Test plan
- Stream 9'b0010_00101 (ADD), 9'b0111_00011 (LW), 9'b1000_00001 (SW), out_ready=1 -> three records on consecutive cycles; ctl_reg_we=1/ctl_mem_re=1/ctl_mem_we=1 respectively, retired=3.
- Escape 9'b1110_00100 (ADDI) then 9'h0A5 -> single record out_is_imm=1, out_sub=4, out_imm=9'h0A5, ctl_reg_we=1; retired +1 only.
- Escape 9'b1110_01001 (sub 9) -> out_illegal=1, all ctl_*=0, next word decoded normally in RUN.
- STOP 9'b1111_00000 with out_ready=0 for 3 cycles -> record held, halted=1, in_ready=0; resume pulse -> halted=0, in_ready=1 next cycle.
- Assert reset_n=0 while in IMM_WAIT, release, send 9'b0100_00010 -> decoded as B (ctl_branch=1), not as immediate; retired=1.
- Preload retired to 16'hFFFF path (2^16 handoffs or forced CW=4 build) -> wraps to 0 on next handoff.
